// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg: keystroke output codes, set-2 scan codes and frame FSM encoding
// Revision: 1.0
`default_nettype none

package ps2_key_pkg;

  localparam logic [4:0] KEY_NONE  = 5'd0;
  localparam logic [4:0] KEY_A = 5'd1,  KEY_B = 5'd2,  KEY_C = 5'd3,  KEY_D = 5'd4;
  localparam logic [4:0] KEY_E = 5'd5,  KEY_F = 5'd6,  KEY_G = 5'd7,  KEY_H = 5'd8;
  localparam logic [4:0] KEY_I = 5'd9,  KEY_J = 5'd10, KEY_K = 5'd11, KEY_L = 5'd12;
  localparam logic [4:0] KEY_M = 5'd13, KEY_N = 5'd14, KEY_O = 5'd15, KEY_P = 5'd16;
  localparam logic [4:0] KEY_Q = 5'd17, KEY_R = 5'd18, KEY_S = 5'd19, KEY_T = 5'd20;
  localparam logic [4:0] KEY_U = 5'd21, KEY_V = 5'd22, KEY_W = 5'd23, KEY_X = 5'd24;
  localparam logic [4:0] KEY_Y = 5'd25, KEY_Z = 5'd26;
  localparam logic [4:0] KEY_SPACE = 5'd27, KEY_BKSP = 5'd28, KEY_ENTER = 5'd29;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_A = 8'h1C, SC_B = 8'h32, SC_C = 8'h21, SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24, SC_F = 8'h2B, SC_G = 8'h34, SC_H = 8'h33;
  localparam logic [7:0] SC_I = 8'h43, SC_J = 8'h3B, SC_K = 8'h42, SC_L = 8'h4B;
  localparam logic [7:0] SC_M = 8'h3A, SC_N = 8'h31, SC_O = 8'h44, SC_P = 8'h4D;
  localparam logic [7:0] SC_Q = 8'h15, SC_R = 8'h2D, SC_S = 8'h1B, SC_T = 8'h2C;
  localparam logic [7:0] SC_U = 8'h3C, SC_V = 8'h2A, SC_W = 8'h1D, SC_X = 8'h22;
  localparam logic [7:0] SC_Y = 8'h35, SC_Z = 8'h1A;
  localparam logic [7:0] SC_SPACE = 8'h29, SC_BKSP = 8'h66, SC_ENTER = 8'h5A;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_RECV  = 2'd1,
    RX_CHECK = 2'd2
  } rx_state_t;

  // Unmapped scan codes return KEY_NONE so the decoder can drop them.
  function automatic logic [4:0] scan_to_key(input logic [7:0] sc);
    logic [4:0] k;
    case (sc)
      SC_A: k = KEY_A;  SC_B: k = KEY_B;  SC_C: k = KEY_C;  SC_D: k = KEY_D;
      SC_E: k = KEY_E;  SC_F: k = KEY_F;  SC_G: k = KEY_G;  SC_H: k = KEY_H;
      SC_I: k = KEY_I;  SC_J: k = KEY_J;  SC_K: k = KEY_K;  SC_L: k = KEY_L;
      SC_M: k = KEY_M;  SC_N: k = KEY_N;  SC_O: k = KEY_O;  SC_P: k = KEY_P;
      SC_Q: k = KEY_Q;  SC_R: k = KEY_R;  SC_S: k = KEY_S;  SC_T: k = KEY_T;
      SC_U: k = KEY_U;  SC_V: k = KEY_V;  SC_W: k = KEY_W;  SC_X: k = KEY_X;
      SC_Y: k = KEY_Y;  SC_Z: k = KEY_Z;
      SC_SPACE: k = KEY_SPACE;
      SC_BKSP:  k = KEY_BKSP;
      SC_ENTER: k = KEY_ENTER;
      default:  k = KEY_NONE;
    endcase
    return k;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_keystroke_source_if.sv
// ps2_keystroke_source_if: PS/2 pins in, keystroke/key_released/status out
// Revision: 1.0
`default_nettype none

interface ps2_keystroke_source_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [4:0] keystroke;
  logic       key_released;
  logic       key_valid;
  logic       frame_err;

  modport master (
    input  ps2_clk, ps2_data,
    output keystroke, key_released, key_valid, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  keystroke, key_released, key_valid, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: pin synchronizers, falling-edge detect, 11-bit frame FSM with timeout
// Revision: 1.0
`default_nettype none

module ps2_rx_frame
  import ps2_key_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TIMEOUT_US  = 200,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int TIMEOUT_CYCLES = (CLK_HZ / 1_000_000) * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] C_TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  rx_state_t              r_state;
  rx_state_t              w_state_nxt;
  logic [3:0]             r_bit_cnt;
  logic [9:0]             r_shift;
  logic [TW-1:0]          r_timer;
  logic [7:0]             r_byte;
  logic                   r_byte_valid;
  logic                   r_frame_err;

  logic w_sync_clk;
  logic w_sync_data;
  logic w_fall;
  logic w_timeout;
  logic w_check_ok;
  logic w_check_err;

  assign w_sync_clk  = r_clk_sync[SYNC_STAGES-1];
  assign w_sync_data = r_data_sync[SYNC_STAGES-1];
  assign w_fall      = r_clk_prev & ~w_sync_clk;

  always_ff @(posedge clk) begin
    if (reset) r_state <= RX_IDLE;
    else       r_state <= w_state_nxt;
  end

  // r_shift fills from the top, so after ten samples [7:0]=data, [8]=parity, [9]=stop.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_check_ok  = 1'b0;
    w_check_err = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (w_fall && !w_sync_data) w_state_nxt = RX_RECV;
      end
      RX_RECV: begin
        if (w_fall) begin
          if (r_bit_cnt == 4'd9) w_state_nxt = RX_CHECK;
        end else if (r_timer == C_TIMER_MAX) begin
          w_state_nxt = RX_IDLE;
          w_timeout   = 1'b1;
        end
      end
      RX_CHECK: begin
        w_state_nxt = RX_IDLE;
        if ((^r_shift[8:0]) && r_shift[9]) w_check_ok  = 1'b1;
        else                               w_check_err = 1'b1;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_sync   <= '1;
      r_data_sync  <= '1;
      r_clk_prev   <= 1'b1;
      r_bit_cnt    <= 4'd0;
      r_shift      <= 10'd0;
      r_timer      <= '0;
      r_byte       <= 8'd0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_data_sync  <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_clk_prev   <= w_sync_clk;
      r_byte_valid <= w_check_ok;
      r_frame_err  <= w_check_err | w_timeout;
      if (w_check_ok) r_byte <= r_shift[7:0];
      if (r_state == RX_RECV) begin
        if (w_fall) begin
          r_shift   <= {w_sync_data, r_shift[9:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
          r_timer   <= '0;
        end else begin
          r_timer   <= r_timer + 1'b1;
        end
      end else begin
        r_bit_cnt <= 4'd0;
        r_timer   <= '0;
      end
    end
  end

  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;

endmodule

`default_nettype wire

// File: rtl/ps2_keystroke_source.sv
// ps2_keystroke_source: PS/2 set-2 make/break decoder driving keystroke/key_released.
// Optional macro KEY_REPEAT_FILTER_EN suppresses typematic repeats. Revision: 1.0
`default_nettype none

module ps2_keystroke_source
  import ps2_key_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TIMEOUT_US  = 200,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  ps2_keystroke_source_if.master bus
);

  logic [7:0] w_rx_byte;
  logic       w_rx_valid;
  logic       w_rx_err;
  logic [4:0] w_code;
  logic       w_repeat;

  logic [4:0] r_keystroke;
  logic       r_key_released;
  logic       r_key_valid;
  logic       r_brk;
  logic       r_ext;

  ps2_rx_frame #(
    .CLK_HZ      (CLK_HZ),
    .TIMEOUT_US  (TIMEOUT_US),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk          (clk),
    .reset        (reset),
    .i_ps2_clk    (bus.ps2_clk),
    .i_ps2_data   (bus.ps2_data),
    .o_byte       (w_rx_byte),
    .o_byte_valid (w_rx_valid),
    .o_frame_err  (w_rx_err)
  );

  assign w_code = scan_to_key(w_rx_byte);

`ifdef KEY_REPEAT_FILTER_EN
  assign w_repeat = (w_code == r_keystroke) && !r_key_released;
`else
  assign w_repeat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_keystroke    <= KEY_NONE;
      r_key_released <= 1'b1;
      r_key_valid    <= 1'b0;
      r_brk          <= 1'b0;
      r_ext          <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_rx_err) begin
        r_brk <= 1'b0;
        r_ext <= 1'b0;
      end else if (w_rx_valid) begin
        if (w_rx_byte == SC_BREAK) begin
          r_brk <= 1'b1;
        end else if (w_rx_byte == SC_EXT) begin
          r_ext <= 1'b1;
        end else begin
          r_brk <= 1'b0;
          r_ext <= 1'b0;
          // Extended keys are not tracked; a break only releases the key being shown.
          if (!r_ext && (w_code != KEY_NONE)) begin
            if (!r_brk) begin
              if (!w_repeat) begin
                r_keystroke    <= w_code;
                r_key_released <= 1'b0;
                r_key_valid    <= 1'b1;
              end
            end else if (w_code == r_keystroke) begin
              r_key_released <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.keystroke    = r_keystroke;
  assign bus.key_released = r_key_released;
  assign bus.key_valid    = r_key_valid;
  assign bus.frame_err    = w_rx_err;

endmodule

`default_nettype wire
